gamma_inverse_search: RTL and testbench
=======================================

Name: gamma_inverse_search

Overview:
- Inverse of the 16-bit gamma correction curve: maps a 16-bit linear intensity back to the 8-bit code whose corrected value best matches it.
- Used to read back and report frame/PWM state as 8-bit codes, and to re-quantise 16-bit blended values before SPI transmission.
- Sequential MSB-first binary search over a forward-curve ROM, one bit per cycle; valid/ready on both sides.

Parameters:
- LIN_W, 16, linear input width; the ROM is generated for 16 only.
- CODE_W, 8, code width and number of search steps; the ROM is generated for 8 only.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- in_linear  input  LIN_W  linear intensity to convert
- in_valid  input  1  in_linear is valid
- in_ready  output  1  block accepts input; high only in IDLE
- out_code  output  CODE_W  result code
- out_valid  output  1  out_code is valid
- out_ready  input  1  downstream accepts the result

Behaviour:
- Reset and clocking: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1 (combinational from state), out_valid=0, out_code=0, internal code/bit index=0.
- Curve: curve(c)=round(65535*(c/255)^1.8), c=0..255, monotonic non-decreasing.
  - Anchors: curve(0)=0, curve(1)=3, curve(127)=18687, curve(128)=18953, curve(254)=65073, curve(255)=65535.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready: lin_q<=in_linear, code<=0, idx<=7, go to SEARCH.
- State SEARCH (one step per cycle):
  - trial=code|(1<<idx); if curve(trial)<=lin_q then code<=trial.
  - If idx==0, go to DONE (or ROUND when the feature is enabled); else idx<=idx-1.
  - Result is floor-inverse: the largest c with curve(c)<=lin_q. lin_q>=0 always yields at least 0.
- State DONE:
  - out_valid=1, out_code=code, held stable until out_ready.
  - On out_valid&out_ready, go to IDLE.
- Latency: the accepting edge is E0. Search runs on edges E1..E8. out_valid is high after E8, so latency is 8 cycles (9 with rounding).
- Throughput: earliest next accept is one cycle after the output handshake. Minimum period is 10 cycles (11 with rounding).
- Simultaneous events:
  - In DONE, in_ready=0, so in_valid is ignored and no input is accepted in the handshake cycle.
  - in_linear is sampled only on the accept edge; later changes have no effect.
- Backpressure: out_ready low holds DONE indefinitely with out_code unchanged.
- Reset mid-operation: async return to IDLE. Any in-flight result is discarded; out_valid drops immediately.
- Arithmetic: all comparisons are unsigned, LIN_W bits. Differences in ROUND use LIN_W-bit unsigned values; no overflow is possible because operands are ordered.

Optional Feature:
- Macro: GAMMA_INV_ROUND_NEAREST_EN.
- Defined: adds a ROUND state after SEARCH.
  - If code<255, compute lo=lin_q-curve(code) and hi=curve(code+1)-lin_q.
  - If hi<lo, code<=code+1. Ties keep the lower code.
  - code==255 is unchanged. Then go to DONE.
- Undefined: no ROUND state; floor result, latency 8.

Decomposition:
- Shared package gamma_pkg holds:
  - constants GAMMA_LIN_W=16, GAMMA_CODE_W=8
  - state enum {IDLE, SEARCH, ROUND, DONE}
  - gamma exponent note and ROM generator constants.
- One sub-module, gamma_curve_rom: combinational 8-bit code to 16-bit curve value, same curve as above.
  - Instantiated once and shared between the SEARCH trial and the ROUND neighbour by muxing its address by state.

Test Plan:
- Exact points, floor build: in_linear 0→0, 3→1, 18953→128, 65535→255. Each out_valid 8 cycles after accept.
- Between points, floor build: 18952→127, 2→0, 65534→254.
  - Rounding build: 18952→128 (distances 265 vs 1), 2→1, 65534→255, 18820→127 (distances 133/133, tie keeps lower).
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. out_code stays stable and in_ready stays 0. Release: handshake, then in_ready=1 next cycle.
- Back-to-back: in_valid held high with values 100, 40000. Accepts are 10 cycles apart (floor build).
  - Results are floor-inverse(100)=6 and floor-inverse(40000)=193, since curve(193)=39692≤40000<40063.
- Reset mid-search: assert rst 4 cycles after accepting 30000. out_valid=0 and in_ready=1 during/after reset. Next input 0 returns 0 with normal latency.
- Exhaustive: all 65536 inputs checked against the reference curve model (floor, and nearest when the macro is defined).

Source files
------------

// File: rtl/gamma_pkg.sv
// Shared constants, FSM state type and forward gamma curve generator for gamma_inverse_search.
// The curve generator is a constant function evaluated at elaboration to build the ROM contents.
package gamma_pkg;

    localparam int GAMMA_LIN_W  = 16;
    localparam int GAMMA_CODE_W = 8;

    // Gamma exponent 1.8 is held as the exact ratio 9/5 so the ROM can be built with integers only.
    localparam int GAMMA_EXP_NUM    = 9;
    localparam int GAMMA_EXP_DEN    = 5;
    localparam int GAMMA_FULL_SCALE = 65535;
    localparam int GAMMA_CODE_MAX   = 255;
    localparam int GAMMA_CALC_W     = 160;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } gamma_state_e;

    // round(FS*(c/MAX)^(9/5)) is the largest y with (y-0.5) <= that value; raising both sides
    // to the 5th power and doubling clears every fraction, leaving an exact wide-integer compare.
    function automatic logic [GAMMA_LIN_W-1:0] gamma_curve_calc(input logic [GAMMA_CODE_W-1:0] c);
        logic [GAMMA_CALC_W-1:0] rhs;
        logic [GAMMA_CALC_W-1:0] lhs;
        logic [GAMMA_CALC_W-1:0] twice_minus_one;
        logic [GAMMA_LIN_W-1:0]  y;
        logic [GAMMA_LIN_W-1:0]  trial;
        rhs = GAMMA_CALC_W'(32);
        for (int k = 0; k < GAMMA_EXP_NUM; k++) begin
            rhs = rhs * GAMMA_CALC_W'(c);
        end
        for (int k = 0; k < GAMMA_EXP_DEN; k++) begin
            rhs = rhs * GAMMA_CALC_W'(GAMMA_FULL_SCALE);
        end
        y = '0;
        for (int b = GAMMA_LIN_W - 1; b >= 0; b--) begin
            trial           = y | (GAMMA_LIN_W'(1) << b);
            twice_minus_one = GAMMA_CALC_W'({trial, 1'b0}) - GAMMA_CALC_W'(1);
            lhs             = twice_minus_one;
            for (int k = 1; k < GAMMA_EXP_DEN; k++) begin
                lhs = lhs * twice_minus_one;
            end
            for (int k = 0; k < GAMMA_EXP_NUM; k++) begin
                lhs = lhs * GAMMA_CALC_W'(GAMMA_CODE_MAX);
            end
            if (lhs <= rhs) begin
                y = trial;
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/gamma_curve_rom.sv
// Combinational forward gamma curve: 8-bit code to 16-bit linear value.
// Table contents are fixed at elaboration from gamma_curve_calc.
module gamma_curve_rom
    import gamma_pkg::*;
(
    input  logic [GAMMA_CODE_W-1:0] addr_i,
    output logic [GAMMA_LIN_W-1:0]  value_o
);

    logic [GAMMA_LIN_W-1:0] rom [2**GAMMA_CODE_W];

    for (genvar g = 0; g < 2**GAMMA_CODE_W; g++) begin : g_rom
        localparam logic [GAMMA_LIN_W-1:0] VAL = gamma_curve_calc(GAMMA_CODE_W'(g));
        assign rom[g] = VAL;
    end

    assign value_o = rom[addr_i];

endmodule

// File: rtl/gamma_inverse_search.sv
// Inverse gamma: MSB-first binary search over the forward curve ROM, one code bit per cycle.
// GAMMA_INV_ROUND_NEAREST_EN adds a ROUND step choosing the nearer of floor code and its successor.
module gamma_inverse_search
    import gamma_pkg::*;
#(
    parameter int LIN_W  = GAMMA_LIN_W,
    parameter int CODE_W = GAMMA_CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LIN_W-1:0]  in_linear,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int IDX_W = $clog2(CODE_W);

    // Handshake: a transfer happens on a clock edge where valid and ready are both high;
    // in_ready is high only in IDLE and out_valid only in DONE, so the two never overlap.

    gamma_state_e      state_q, state_d;
    logic [LIN_W-1:0]  lin_q, lin_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CODE_W-1:0] trial;
    logic [CODE_W-1:0] rom_addr;
    logic [LIN_W-1:0]  rom_val;

    assign trial = code_q | (CODE_W'(1) << idx_q);

    // One ROM serves both the search trial and the upper neighbour looked at in ROUND.
    assign rom_addr = (state_q == ROUND) ? (code_q + CODE_W'(1)) : trial;

    gamma_curve_rom u_rom (
        .addr_i  (rom_addr),
        .value_o (rom_val)
    );

`ifdef GAMMA_INV_ROUND_NEAREST_EN
    // curve(code_q), captured whenever a trial is kept, so ROUND needs only one ROM read.
    logic [LIN_W-1:0] cur_q, cur_d;
    logic [LIN_W-1:0] dist_lo;
    logic [LIN_W-1:0] dist_hi;

    assign dist_lo = lin_q - cur_q;
    assign dist_hi = rom_val - lin_q;
`endif

    always_comb begin
        state_d = state_q;
        lin_d   = lin_q;
        code_d  = code_q;
        idx_d   = idx_q;
`ifdef GAMMA_INV_ROUND_NEAREST_EN
        cur_d   = cur_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    lin_d   = in_linear;
                    code_d  = '0;
                    idx_d   = IDX_W'(CODE_W - 1);
`ifdef GAMMA_INV_ROUND_NEAREST_EN
                    cur_d   = '0;
`endif
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (rom_val <= lin_q) begin
                    code_d = trial;
`ifdef GAMMA_INV_ROUND_NEAREST_EN
                    cur_d  = rom_val;
`endif
                end
                if (idx_q == '0) begin
`ifdef GAMMA_INV_ROUND_NEAREST_EN
                    state_d = ROUND;
`else
                    state_d = DONE;
`endif
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            ROUND: begin
`ifdef GAMMA_INV_ROUND_NEAREST_EN
                // Floor guarantees curve(code+1) > lin_q, so dist_hi cannot wrap; ties keep lower.
                if ((code_q != '1) && (dist_hi < dist_lo)) begin
                    code_d = code_q + CODE_W'(1);
                end
`endif
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lin_q   <= '0;
            code_q  <= '0;
            idx_q   <= '0;
`ifdef GAMMA_INV_ROUND_NEAREST_EN
            cur_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            lin_q   <= lin_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
`ifdef GAMMA_INV_ROUND_NEAREST_EN
            cur_q   <= cur_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_code  = code_q;

endmodule

// File: tb/tb_gamma_inverse_search.sv
// Self-checking bench for gamma_inverse_search: real-valued curve model, expected-result queue,
// directed vectors with literal expectations, backpressure, back-to-back, reset and a curve sweep.
module tb_gamma_inverse_search;

`ifdef GAMMA_INV_ROUND_NEAREST_EN
    localparam int ROUND_EN = 1;
    localparam int LAT      = 9;
    localparam int PERIOD   = 11;
`else
    localparam int ROUND_EN = 0;
    localparam int LAT      = 8;
    localparam int PERIOD   = 10;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] in_linear;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_code;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int acc_cyc  = 0;
    int prev_acc_cyc = 0;
    logic [7:0] exp_q[$];
    int curve_tab[256];

    gamma_inverse_search dut (
        .clk       (clk),
        .rst       (rst),
        .in_linear (in_linear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: curve from real arithmetic, inverse by scanning the whole table
    function automatic int ref_curve(input int c);
        real r;
        r = 65535.0 * $pow(c / 255.0, 1.8);
        return $rtoi(r + 0.5);
    endfunction

    function automatic int ref_inverse(input int x);
        int c;
        c = 0;
        for (int k = 0; k < 256; k++) begin
            if (curve_tab[k] <= x) c = k;
        end
        if (ROUND_EN != 0 && c < 255 && (curve_tab[c+1] - x) < (x - curve_tab[c])) c++;
        return c;
    endfunction

    // accept monitor: every input handshake pushes the model's answer
    always @(posedge clk) begin
        cyc++;
        if (!rst && in_valid && in_ready) begin
            prev_acc_cyc = acc_cyc;
            acc_cyc      = cyc;
            acc_cnt++;
            exp_q.push_back(8'(ref_inverse(int'(in_linear))));
        end
    end

    // compare process: checks outputs on every cycle they are meaningful
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (out_valid) begin
            check("in_ready_low_in_done", 32'(in_ready), 32'd0);
            check("result_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("out_code", 32'(out_code), 32'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // driver: one full transaction, called and returning at posedge+#1
    task automatic run_vec(input int v, input int lit);
        int t;
        int n0;
        in_linear = 16'(v);
        in_valid  = 1'b1;
        n0 = acc_cnt;
        t  = 0;
        while (acc_cnt == n0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        check("accept_seen", 32'(acc_cnt - n0), 32'd1);
        t = 0;
        while (!out_valid && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("latency", 32'(t), 32'(LAT));
        if (lit >= 0) check("direct_code", 32'(out_code), 32'(lit));
        @(posedge clk); #1;
    endtask

    int dv_in[10]    = '{0, 3, 18953, 65535, 18952, 2, 65534, 18820, 100, 40000};
    int dv_floor[10] = '{0, 1, 128, 255, 127, 0, 254, 127, 6, 193};
    int dv_round[10] = '{0, 1, 128, 255, 128, 1, 255, 127, 7, 194};

    initial begin
        int t;
        int n0;
        int lit;
        int first_code;
        int mid;

        for (int k = 0; k < 256; k++) curve_tab[k] = ref_curve(k);

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_linear = '0;
        out_ready = 1'b1;

        // model pins
        check("model_curve_0",   32'(curve_tab[0]),   32'd0);
        check("model_curve_1",   32'(curve_tab[1]),   32'd3);
        check("model_curve_127", 32'(curve_tab[127]), 32'd18687);
        check("model_curve_128", 32'(curve_tab[128]), 32'd18953);
        check("model_curve_193", 32'(curve_tab[193]), 32'd39692);
        check("model_curve_194", 32'(curve_tab[194]), 32'd40063);
        check("model_curve_254", 32'(curve_tab[254]), 32'd65073);
        check("model_curve_255", 32'(curve_tab[255]), 32'd65535);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_code",  32'(out_code),  32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // directed vectors
        for (int i = 0; i < 10; i++) begin
            lit = (ROUND_EN != 0) ? dv_round[i] : dv_floor[i];
            check("model_pin_inverse", 32'(ref_inverse(dv_in[i])), 32'(lit));
            run_vec(dv_in[i], lit);
        end

        // backpressure: out_ready low for 20 cycles, stray in_valid ignored
        lit = (ROUND_EN != 0) ? 128 : 127;
        out_ready = 1'b0;
        in_linear = 16'd18952;
        in_valid  = 1'b1;
        n0 = acc_cnt;
        t  = 0;
        while (acc_cnt == n0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("bp_latency", 32'(t), 32'(LAT));
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_linear = 16'd5;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready",   32'(in_ready),  32'd0);
            check("bp_code",       32'(out_code),  32'(lit));
        end
        in_valid = 1'b0;
        n0 = acc_cnt;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(out_valid), 32'd0);
        check("bp_release_ready", 32'(in_ready),  32'd1);
        check("bp_no_stray_accept", 32'(acc_cnt), 32'(n0));

        // back-to-back with in_valid held; in_linear changes mid-search
        n0 = acc_cnt;
        first_code = -1;
        in_linear = 16'd100;
        in_valid  = 1'b1;
        t = 0;
        while (acc_cnt == n0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        in_linear = 16'd40000;
        while (acc_cnt < n0 + 2 && t < 100) begin
            @(posedge clk); #1;
            if (out_valid) first_code = int'(out_code);
            t++;
        end
        in_valid = 1'b0;
        check("b2b_accepts", 32'(acc_cnt - n0), 32'd2);
        check("b2b_period",  32'(acc_cyc - prev_acc_cyc), 32'(PERIOD));
        check("b2b_first",   32'(first_code), (ROUND_EN != 0) ? 32'd7 : 32'd6);
        t = 0;
        while (!out_valid && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        check("b2b_second", 32'(out_code), (ROUND_EN != 0) ? 32'd194 : 32'd193);
        @(posedge clk); #1;

        // reset mid-search
        n0 = acc_cnt;
        in_linear = 16'd30000;
        in_valid  = 1'b1;
        t = 0;
        while (acc_cnt == n0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready",  32'(in_ready),  32'd1);
        @(posedge clk); #1;
        check("rst_hold_in_ready", 32'(in_ready),  32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_after_valid", 32'(out_valid), 32'd0);
        check("rst_queue_empty", 32'(exp_q.size()), 32'd0);
        run_vec(0, 0);

        // sweep: every curve point, the value just below it, and both sides of each midpoint
        for (int c = 0; c < 256; c++) begin
            run_vec(curve_tab[c], -1);
            if (curve_tab[c] > 0) run_vec(curve_tab[c] - 1, -1);
            if (c < 255) begin
                mid = (curve_tab[c] + curve_tab[c+1]) / 2;
                run_vec(mid, -1);
                run_vec(mid + 1, -1);
            end
        end

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
